// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch conditioning front end feeding nclug.
package switch_debounce_pkg;
  localparam logic [15:0] DEBOUNCE_STABLE_COUNT     = 16'd50000;
  localparam logic [15:0] DEBOUNCE_STABLE_COUNT_SIM = 16'd4;

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_COUNT  = 1'b1;
endpackage

// File: rtl/switch_debounce_channel.sv
// One switch: 2-flop synchroniser, counter debounce, registered rise/fall strobes.
module debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter logic [15:0] STABLE_COUNT = DEBOUNCE_STABLE_COUNT,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 16'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1_q, s2_q;
  logic [0:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s2_q != level_q) begin
          cnt_d   = CNT_ONE;
          state_d = ST_COUNT;
        end else begin
          cnt_d = '0;
        end
      end
      ST_COUNT: begin
        if (s2_q == level_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          // Level and strobe flip on the same edge so they always coincide.
          level_d = ~level_q;
          rise_d  = ~level_q;
          fall_d  = level_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= sw_raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/switch_debounce.sv
// Conditions the two raw board switches into nclug sw_0/sw_1 plus edge strobes.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter logic [15:0] STABLE_COUNT = DEBOUNCE_STABLE_COUNT,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_raw_0,
  input  logic       sw_raw_1,
  output logic       sw_0,
  output logic       sw_1,
  output logic [1:0] sw_rise,
  output logic [1:0] sw_fall
);
  debounce_channel #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_ch0 (
    .clk     (clk),
    .rst     (rst),
    .sw_raw_i(sw_raw_0),
    .level_o (sw_0),
    .rise_o  (sw_rise[0]),
    .fall_o  (sw_fall[0])
  );

  debounce_channel #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .sw_raw_i(sw_raw_1),
    .level_o (sw_1),
    .rise_o  (sw_rise[1]),
    .fall_o  (sw_fall[1])
  );
endmodule
